// File: rtl/tdm_demux16.sv
// ============================================================================
// Module      : tdm_demux16
// Description : Serial TDM to parallel-lane demultiplexer with an internal slot
//               counter and a valid/ready frame output. Define TDM_PARITY_EN to
//               add an even-parity slot at the end of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux16 #(
    parameter int LANES = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_sync,
    output logic [LANES-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef TDM_PARITY_EN
    output logic [SEL_W:0]   slot,
`else
    output logic [SEL_W-1:0] slot,
`endif
    output logic             frame_err,
`ifdef TDM_PARITY_EN
    output logic             overrun,
    output logic             parity_err
`else
    output logic             overrun
`endif
);

`ifdef TDM_PARITY_EN
    localparam int c_slot_w = SEL_W + 1;
    localparam int c_sh_w   = LANES;
    localparam logic [c_slot_w-1:0] c_last = c_slot_w'(LANES);
`else
    // The last data bit goes straight to data_out, so the shadow holds one bit fewer.
    localparam int c_slot_w = SEL_W;
    localparam int c_sh_w   = LANES - 1;
    localparam logic [c_slot_w-1:0] c_last = c_slot_w'(LANES - 1);
`endif

    logic [c_slot_w-1:0] r_slot;
    logic [c_sh_w-1:0]   r_shadow;
    logic [LANES-1:0]    r_data;
    logic                r_valid;
    logic                r_ferr;
    logic                r_ovr;
`ifdef TDM_PARITY_EN
    logic                r_perr;
`endif

    logic [SEL_W-1:0]    w_idx;
    logic                w_last;
    logic                w_xfer;

    assign w_idx  = r_slot[SEL_W-1:0];
    assign w_last = (r_slot == c_last);
    assign w_xfer = r_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot   <= '0;
            r_shadow <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
`ifdef TDM_PARITY_EN
            r_perr   <= 1'b0;
`endif
        end else begin
            r_ferr <= 1'b0;
            if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (in_valid) begin
                if (in_sync) begin
                    // Sync restarts the frame; any partial frame is silently dropped.
                    r_shadow <= c_sh_w'(in_bit);
                    r_slot   <= c_slot_w'(1);
                    r_ferr   <= (r_slot != '0);
                end else if (w_last) begin
                    r_slot  <= '0;
                    r_valid <= 1'b1;
                    if (r_valid && !out_ready) begin
                        r_ovr <= 1'b1;
                    end
`ifdef TDM_PARITY_EN
                    r_data <= r_shadow;
                    r_perr <= ^{r_shadow, in_bit};
`else
                    r_data <= {in_bit, r_shadow};
`endif
                end else begin
                    r_shadow[w_idx] <= in_bit;
                    r_slot          <= r_slot + c_slot_w'(1);
                end
            end
        end
    end

    assign data_out   = r_data;
    assign out_valid  = r_valid;
    assign slot       = r_slot;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
`ifdef TDM_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux16.sv
// ============================================================================
// Module      : tb_tdm_demux16
// Description : Directed self-checking bench for tdm_demux16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux16;

`ifdef TDM_PARITY_EN
    localparam int FLEN = 17;
    localparam int SW   = 5;
`else
    localparam int FLEN = 16;
    localparam int SW   = 4;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_bit;
    logic          in_valid;
    logic          in_sync;
    logic [15:0]   data_out;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] slot;
    logic          frame_err;
    logic          overrun;
`ifdef TDM_PARITY_EN
    logic          parity_err;
`endif

    int total = 0;
    int bad   = 0;

    tdm_demux16 #(.LANES(16), .SEL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot),
        .frame_err (frame_err),
`ifdef TDM_PARITY_EN
        .overrun   (overrun),
        .parity_err(parity_err)
`else
        .overrun   (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit i of a transmitted frame; the extra slot (if present) carries even parity.
    function automatic logic fbit(input logic [15:0] w, input int i);
        if (i < 16) return w[i];
        return ^w;
    endfunction

    task automatic step(input logic v, input logic b, input logic s);
        in_valid = v;
        in_bit   = b;
        in_sync  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_sync = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (data_out !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", data_out); end
        total++; if (slot !== '0) begin bad++; $display("FAIL reset_slot got=%0d exp=0", slot); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        total++; if (slot !== '0) begin bad++; $display("FAIL idle_sync_ignored slot got=%0d exp=0", slot); end
    endtask

    task automatic test_basic;
        logic [15:0] w;
        w = 16'hA5C3;
        out_ready = 1'b1;
        for (int i = 0; i < FLEN - 1; i++) step(1'b1, fbit(w, i), i == 0);
        total++; if (slot !== SW'(FLEN - 1)) begin bad++; $display("FAIL basic_slot_last got=%0d exp=%0d", slot, FLEN - 1); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        step(1'b1, fbit(w, FLEN - 1), 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (data_out !== 16'hA5C3) begin bad++; $display("FAIL basic_data got=%h exp=a5c3", data_out); end
        total++; if (slot !== '0) begin bad++; $display("FAIL basic_slot_wrap got=%0d exp=0", slot); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL basic_frame_err got=%b exp=0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL basic_overrun got=%b exp=0", overrun); end
        step(1'b0, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
        total++; if (data_out !== 16'hA5C3) begin bad++; $display("FAIL basic_data_hold got=%h exp=a5c3", data_out); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] w [2];
        w[0] = 16'h0001;
        w[1] = 16'h8000;
        out_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FLEN; i++) begin
                step(1'b1, fbit(w[f], i), i == 0);
                total++;
                if (out_valid !== (i == FLEN - 1)) begin
                    bad++; $display("FAIL b2b_valid frame=%0d bit=%0d got=%b exp=%b", f, i, out_valid, i == FLEN - 1);
                end
                if (frame_err !== 1'b0) begin
                    total++; bad++; $display("FAIL b2b_frame_err frame=%0d bit=%0d got=1 exp=0", f, i);
                end
            end
            total++; if (data_out !== w[f]) begin bad++; $display("FAIL b2b_data frame=%0d got=%h exp=%h", f, data_out, w[f]); end
        end
        step(1'b0, 1'b0, 1'b0);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_overrun;
        out_ready = 1'b0;
        for (int i = 0; i < FLEN; i++) step(1'b1, fbit(16'h1234, i), i == 0);
        total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL ovr_first_data got=%h exp=1234", data_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b exp=0", overrun); end
        for (int i = 0; i < FLEN; i++) step(1'b1, fbit(16'hFFFF, i), i == 0);
        total++; if (data_out !== 16'hFFFF) begin bad++; $display("FAIL ovr_data got=%h exp=ffff", data_out); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        out_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_valid_drop got=%b exp=0", out_valid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        step(1'b0, 1'b0, 1'b0);
        total++; if (data_out !== 16'hFFFF) begin bad++; $display("FAIL ovr_data_hold got=%h exp=ffff", data_out); end
    endtask

    task automatic test_frame_err;
        logic [4:0] pre;
        int         pulses;
        pre = 5'b01101;
        pulses = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, pre[i], i == 0);
        total++; if (slot !== SW'(5)) begin bad++; $display("FAIL ferr_slot_pre got=%0d exp=5", slot); end
        step(1'b1, 1'b1, 1'b1);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_pulse got=%b exp=1", frame_err); end
        total++; if (slot !== SW'(1)) begin bad++; $display("FAIL ferr_slot_restart got=%0d exp=1", slot); end
        for (int i = 1; i < FLEN; i++) begin
            step(1'b1, fbit(16'h0001, i), 1'b0);
            if (out_valid === 1'b1) pulses++;
            if (i == 1) begin
                total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_one_cycle got=%b exp=0", frame_err); end
            end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL ferr_valid_count got=%0d exp=1", pulses); end
        total++; if (data_out !== 16'h0001) begin bad++; $display("FAIL ferr_data got=%h exp=0001", data_out); end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b1, fbit(16'hA5A5, i), i == 0);
        total++; if (slot !== SW'(9)) begin bad++; $display("FAIL arst_slot_pre got=%0d exp=9", slot); end
        in_valid = 1'b0;
        in_sync  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (slot !== '0) begin bad++; $display("FAIL arst_slot got=%0d exp=0", slot); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL arst_overrun got=%b exp=0", overrun); end
        total++; if (data_out !== 16'h0) begin bad++; $display("FAIL arst_data got=%h exp=0000", data_out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < FLEN; i++) step(1'b1, fbit(16'h00FF, i), i == 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_next_valid got=%b exp=1", out_valid); end
        total++; if (data_out !== 16'h00FF) begin bad++; $display("FAIL arst_next_data got=%h exp=00ff", data_out); end
        step(1'b0, 1'b0, 1'b0);
    endtask

`ifdef TDM_PARITY_EN
    task automatic test_parity;
        logic [16:0] f;
        out_ready = 1'b1;
        f = {1'b0, 16'h0003};
        for (int i = 0; i < 17; i++) step(1'b1, f[i], i == 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL par_ok_valid got=%b exp=1", out_valid); end
        total++; if (data_out !== 16'h0003) begin bad++; $display("FAIL par_ok_data got=%h exp=0003", data_out); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_ok_err got=%b exp=0", parity_err); end
        f = {1'b0, 16'h0007};
        for (int i = 0; i < 17; i++) step(1'b1, f[i], i == 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL par_bad_valid got=%b exp=1", out_valid); end
        total++; if (data_out !== 16'h0007) begin bad++; $display("FAIL par_bad_data got=%h exp=0007", data_out); end
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_bad_err got=%b exp=1", parity_err); end
        step(1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_async_reset();
`ifdef TDM_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- Receive-side counterpart of the 16:1 mux tree.
- Takes a serial TDM stream, one bit per valid cycle, slot 0 first, and steers each bit into its lane register using an internal slot counter in place of an external select.
- When a full frame has been captured, presents all lanes as a parallel word behind a valid/ready handshake.
- Sits at the far end of a link fed by a mux whose select is driven by a slot counter.

Parameters:
LANES  16  number of lanes per frame; power of two, 2..16
SEL_W  4  slot index width; must equal log2(LANES)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous reset, active-low
in_bit  input  1  serial data bit
in_valid  input  1  in_bit is valid this cycle
in_sync  input  1  qualified by in_valid; marks in_bit as slot 0 of a new frame
data_out  output  LANES  parallel frame; bit k = slot k
out_valid  output  1  data_out holds an unconsumed frame
out_ready  input  1  consumer accepts data_out this cycle
slot  output  SEL_W  index of the next slot to be written (mirror of the transmitter's sel)
frame_err  output  1  one-cycle pulse: in_sync seen while slot != 0
overrun  output  1  sticky: completed frame overwrote an unconsumed frame
parity_err  output  1  only when TDM_PARITY_EN is defined; see Optional Feature

Behaviour:
- Reset (rst_n low, asynchronous), all cleared to 0: slot, shadow register, data_out, out_valid, frame_err, overrun, parity_err. Reset mid-frame discards the partial frame.
- No action on cycles with in_valid=0. in_sync without in_valid is ignored.
- in_valid=1, in_sync=0:
  - shadow[slot] <= in_bit; slot <= slot+1.
  - If slot == LANES-1, the frame completes: data_out <= {in_bit, shadow[LANES-2:0]}, out_valid <= 1, slot wraps to 0.
- in_valid=1, in_sync=1:
  - shadow cleared, shadow[0] <= in_bit, slot <= 1.
  - If slot was != 0, frame_err pulses high for exactly the next cycle and the partial frame is dropped (no out_valid).
  - in_sync with slot == 0 is normal and raises no error.
- Latency: last bit of a frame sampled at edge t gives data_out/out_valid valid after edge t (visible cycle t+1). Back-to-back frames are accepted with no gap cycles.
- Handshake:
  - A transfer occurs on any edge where out_valid && out_ready.
  - out_valid and data_out stay stable until a transfer, unless overrun.
  - Transfer without completion: out_valid <= 0; data_out retains its value.
- Simultaneous transfer and frame completion: out_valid stays 1 and data_out takes the new frame. This is not an overrun.
- Frame completion while out_valid=1 and out_ready=0: data_out is overwritten with the new frame, out_valid stays 1, overrun <= 1. overrun clears only on reset.
- slot is registered and wraps modulo frame length; it never exceeds frame length - 1.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined:
  - Frame length is LANES+1. Slot LANES carries even parity over the LANES data bits; slot counter is SEL_W+1 bits wide.
  - Completion occurs on the parity slot; data_out excludes the parity bit.
  - parity_err is registered with data_out: 1 if XOR of data bits and parity bit is 1. It is valid while out_valid and updates only on completion.
  - An in_sync arriving in the parity slot counts as frame_err.
- Not defined:
  - parity_err port is absent; frame length is LANES; slot is SEL_W bits.

Test Plan:
- Reset then 16 valid bits 0xA5C3 LSB first, in_sync on the first, out_ready=1 → out_valid high 1 cycle, data_out=16'hA5C3, slot returns to 0, frame_err=0, overrun=0.
- Two back-to-back frames 0x0001 then 0x8000, out_ready=1, no gaps → two single-cycle out_valid pulses 16 cycles apart with data 0x0001 then 0x8000.
- Frame 0x1234 with out_ready=0, then frame 0xFFFF → data_out=0xFFFF, out_valid=1, overrun=1. Raising out_ready for 1 cycle drops out_valid; overrun remains 1.
- 5 bits sent, then in_sync with bit=1 followed by 15 bits of 0 → frame_err 1-cycle pulse, exactly one out_valid with data_out=0x0001.
- Assert rst_n=0 asynchronously at slot 9 mid-frame → all outputs 0 immediately without a clock edge. A following full frame 0x00FF decodes correctly.
- TDM_PARITY_EN: frame 0x0003 with parity 0 → parity_err=0; frame 0x0007 with parity 0 → parity_err=1; both frames delivered with out_valid.
